life_engine_param: RTL and testbench

// - Parametrised Game of Life generation engine: computes one generation of a ROWS x COLS board per start request.
// - Sweeps the board one row per cycle rather than fully in parallel; tracks cumulative birth/death statistics,
//   a generation count, and a still-life flag.
// - Sits between the board store/display logic and the control FSM, which pulses start and consumes done.

---
 rtl/life_engine_param_pkg.sv | 26 ++
 rtl/life_engine_param_row_eval.sv | 45 ++++
 rtl/life_engine_param.sv | 172 +++++++++++++++++
 tb/tb_life_engine_param.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_engine_param_pkg.sv
// Shared types and helpers for the Game of Life generation engine.
package life_engine_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Ceiling log2 used to size row indices and counters; returns 0 for v <= 1.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Flat bit position of cell (r,c) on a board with the given width.
  function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_engine_param_row_eval.sv
// Combinational next-state evaluation of one board row from its three-row neighbourhood.
module life_engine_param_row_eval
  import life_engine_param_pkg::*;
#(
  parameter  int unsigned COLS = 16,
  parameter  int unsigned WRAP = 1,
  localparam int unsigned RCW  = clog2_f(COLS + 1)
) (
  input  logic [COLS-1:0] above_i,
  input  logic [COLS-1:0] cur_i,
  input  logic [COLS-1:0] below_i,
  output logic [COLS-1:0] next_o,
  output logic [RCW-1:0]  births_o,
  output logic [RCW-1:0]  deaths_o
);

  // Rows padded by one column each side: bit c+1 is column c, bits 0 and COLS+1 are edge neighbours.
  logic [COLS+1:0] ext_a;
  logic [COLS+1:0] ext_c;
  logic [COLS+1:0] ext_b;

  assign ext_a = {(WRAP != 0) ? above_i[0] : 1'b0, above_i, (WRAP != 0) ? above_i[COLS-1] : 1'b0};
  assign ext_c = {(WRAP != 0) ? cur_i[0]   : 1'b0, cur_i,   (WRAP != 0) ? cur_i[COLS-1]   : 1'b0};
  assign ext_b = {(WRAP != 0) ? below_i[0] : 1'b0, below_i, (WRAP != 0) ? below_i[COLS-1] : 1'b0};

  always_comb begin
    logic [3:0] nb;
    next_o   = '0;
    births_o = '0;
    deaths_o = '0;
    for (int c = 0; c < COLS; c++) begin
      nb = 4'(ext_a[c]) + 4'(ext_a[c+1]) + 4'(ext_a[c+2])
         + 4'(ext_c[c])                  + 4'(ext_c[c+2])
         + 4'(ext_b[c]) + 4'(ext_b[c+1]) + 4'(ext_b[c+2]);
      if (cur_i[c]) begin
        if (nb == 4'd2 || nb == 4'd3) next_o[c] = 1'b1;
        else                          deaths_o  = deaths_o + RCW'(1);
      end else if (nb == 4'd3) begin
        next_o[c] = 1'b1;
        births_o  = births_o + RCW'(1);
      end
    end
  end

endmodule

// File: rtl/life_engine_param.sv
// Row-serial Game of Life engine: one generation per start, with saturating birth/death/generation stats.
module life_engine_param
  import life_engine_param_pkg::*;
#(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned COLS  = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned WRAP  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr_stats,
  input  logic [ROWS*COLS-1:0] board_in,
  output logic [ROWS*COLS-1:0] board_out,
  output logic                 busy,
  output logic                 done,
  output logic                 still,
  output logic [CNT_W-1:0]     birth_cnt,
  output logic [CNT_W-1:0]     death_cnt,
  output logic [CNT_W-1:0]     gen_cnt
);

  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned RIW = clog2_f(ROWS);
  localparam int unsigned RCW = clog2_f(COLS + 1);
  localparam int unsigned GW  = clog2_f(N + 1);
  localparam int unsigned SW  = ((CNT_W > GW) ? CNT_W : GW) + 1;

  state_e           state_q, state_d;
  logic [N-1:0]     snap_q, snap_d;
  logic [N-1:0]     nxt_q, nxt_d;
  logic [RIW-1:0]   row_q, row_d;
  logic [GW-1:0]    gb_q, gb_d;
  logic [GW-1:0]    gd_q, gd_d;
  logic [N-1:0]     out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             still_q, still_d;
  logic [CNT_W-1:0] birth_q, birth_d;
  logic [CNT_W-1:0] death_q, death_d;
  logic [CNT_W-1:0] gen_q, gen_d;

  logic [COLS-1:0]  snap_rows [ROWS];
  logic [COLS-1:0]  up_row, cur_row, dn_row, new_row;
  logic [RCW-1:0]   row_births, row_deaths;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [GW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return CNT_W'(s);
  endfunction

  always_comb begin
    for (int r = 0; r < ROWS; r++) snap_rows[r] = snap_q[r*COLS +: COLS];
  end

  // Neighbour rows of the row under evaluation; vertical wrap handled here, horizontal in the evaluator.
  always_comb begin
    cur_row = snap_rows[row_q];
    if (row_q == '0) up_row = (WRAP != 0) ? snap_rows[ROWS-1] : '0;
    else             up_row = snap_rows[row_q - RIW'(1)];
    if (row_q == RIW'(ROWS-1)) dn_row = (WRAP != 0) ? snap_rows[0] : '0;
    else                       dn_row = snap_rows[row_q + RIW'(1)];
  end

  life_engine_param_row_eval #(
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_row_eval (
    .above_i  (up_row),
    .cur_i    (cur_row),
    .below_i  (dn_row),
    .next_o   (new_row),
    .births_o (row_births),
    .deaths_o (row_deaths)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    nxt_d   = nxt_q;
    row_d   = row_q;
    gb_d    = gb_q;
    gd_d    = gd_q;
    out_d   = out_q;
    still_d = still_q;
    done_d  = 1'b0;
    birth_d = birth_q;
    death_d = death_q;
    gen_d   = gen_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = board_in;
          row_d   = '0;
          gb_d    = '0;
          gd_d    = '0;
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        for (int r = 0; r < ROWS; r++) begin
          if (row_q == RIW'(r)) nxt_d[r*COLS +: COLS] = new_row;
        end
        gb_d = gb_q + GW'(row_births);
        gd_d = gd_q + GW'(row_deaths);
        if (row_q == RIW'(ROWS-1)) state_d = ST_COMMIT;
        else                       row_d   = row_q + RIW'(1);
      end
      ST_COMMIT: begin
        out_d   = nxt_q;
        still_d = (nxt_q == snap_q);
        done_d  = 1'b1;
        birth_d = sat_add(birth_q, gb_q);
        death_d = sat_add(death_q, gd_q);
        gen_d   = (gen_q == {CNT_W{1'b1}}) ? gen_q : gen_q + CNT_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Clearing takes priority over the commit's accumulation.
    if (clr_stats) begin
      birth_d = '0;
      death_d = '0;
      gen_d   = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      nxt_q   <= '0;
      row_q   <= '0;
      gb_q    <= '0;
      gd_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      still_q <= 1'b0;
      birth_q <= '0;
      death_q <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      nxt_q   <= nxt_d;
      row_q   <= row_d;
      gb_q    <= gb_d;
      gd_q    <= gd_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      still_q <= still_d;
      birth_q <= birth_d;
      death_q <= death_d;
      gen_q   <= gen_d;
    end
  end

  assign board_out = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign still     = still_q;
  assign birth_cnt = birth_q;
  assign death_cnt = death_q;
  assign gen_cnt   = gen_q;

endmodule

// File: tb/tb_life_engine_param.sv
// Bench for life_engine_param: three instances (toroidal, bounded, 4-bit counters) share one stimulus stream.
module tb_life_engine_param;

  localparam int R = 16;
  localparam int C = 16;
  localparam int N = R * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, clr_stats;
  logic [N-1:0] board_in;
  logic [N-1:0] bo [3];
  logic [2:0]   busy_v, done_v, still_v;
  logic [31:0]  bc0, dc0, gc0, bc1, dc1, gc1;
  logic [3:0]   bc2, dc2, gc2;

  int passed = 0;
  int total  = 0;

  life_engine_param #(.ROWS(R), .COLS(C), .CNT_W(32), .WRAP(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_stats(clr_stats), .board_in(board_in),
    .board_out(bo[0]), .busy(busy_v[0]), .done(done_v[0]), .still(still_v[0]),
    .birth_cnt(bc0), .death_cnt(dc0), .gen_cnt(gc0));

  life_engine_param #(.ROWS(R), .COLS(C), .CNT_W(32), .WRAP(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_stats(clr_stats), .board_in(board_in),
    .board_out(bo[1]), .busy(busy_v[1]), .done(done_v[1]), .still(still_v[1]),
    .birth_cnt(bc1), .death_cnt(dc1), .gen_cnt(gc1));

  life_engine_param #(.ROWS(R), .COLS(C), .CNT_W(4), .WRAP(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_stats(clr_stats), .board_in(board_in),
    .board_out(bo[2]), .busy(busy_v[2]), .done(done_v[2]), .still(still_v[2]),
    .birth_cnt(bc2), .death_cnt(dc2), .gen_cnt(gc2));

  // Reference model state, one slot per instance.
  longint       cap   [3];
  bit           mwrap [3];
  logic [N-1:0] m_out [3];
  bit           m_still [3];
  longint       m_b [3], m_d [3], m_g [3];

  typedef struct {
    string        name;
    logic [N-1:0] board;
    logic [N-1:0] exp1;
    int           b1, d1;
    bit           s1;
    logic [N-1:0] exp0;
    int           b0, d0;
    bit           s0;
  } vec_t;

  vec_t vecs [4];

  task automatic chk_v(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_i(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [N-1:0] set_cell(input logic [N-1:0] b, input int r, input int c);
    b[r*C+c] = 1'b1;
    return b;
  endfunction

  function automatic longint a_birth(input int i);
    case (i)
      0:       return longint'(bc0);
      1:       return longint'(bc1);
      default: return longint'(bc2);
    endcase
  endfunction

  function automatic longint a_death(input int i);
    case (i)
      0:       return longint'(dc0);
      1:       return longint'(dc1);
      default: return longint'(dc2);
    endcase
  endfunction

  function automatic longint a_gen(input int i);
    case (i)
      0:       return longint'(gc0);
      1:       return longint'(gc1);
      default: return longint'(gc2);
    endcase
  endfunction

  // Conway's rules applied cell by cell with modular or bounded neighbour lookup.
  function automatic void model_step(input logic [N-1:0] b, input bit wrap,
                                     output logic [N-1:0] nb, output int births, output int deaths);
    int n, rr, cc;
    nb = '0;
    births = 0;
    deaths = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + R) % R;
              cc = (cc + C) % C;
            end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) begin
              continue;
            end
            n += int'(b[rr*C+cc]);
          end
        end
        if (b[r*C+c]) begin
          if (n == 2 || n == 3) nb[r*C+c] = 1'b1;
          else deaths++;
        end else if (n == 3) begin
          nb[r*C+c] = 1'b1;
          births++;
        end
      end
    end
  endfunction

  function automatic longint sat(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_gen(input logic [N-1:0] b, input bit clr);
    logic [N-1:0] nb;
    int bb, dd;
    for (int i = 0; i < 3; i++) begin
      model_step(b, mwrap[i], nb, bb, dd);
      m_out[i]   = nb;
      m_still[i] = (nb == b);
      if (clr) begin
        m_b[i] = 0; m_d[i] = 0; m_g[i] = 0;
      end else begin
        m_b[i] = sat(m_b[i] + bb, cap[i]);
        m_d[i] = sat(m_d[i] + dd, cap[i]);
        m_g[i] = sat(m_g[i] + 1, cap[i]);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_out[i] = '0; m_still[i] = 1'b0; m_b[i] = 0; m_d[i] = 0; m_g[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk_v($sformatf("%s_board%0d", tag, i), bo[i], m_out[i]);
      chk_i($sformatf("%s_still%0d", tag, i), longint'(still_v[i]), longint'(m_still[i]));
      chk_i($sformatf("%s_birth%0d", tag, i), a_birth(i), m_b[i]);
      chk_i($sformatf("%s_death%0d", tag, i), a_death(i), m_d[i]);
      chk_i($sformatf("%s_gen%0d", tag, i), a_gen(i), m_g[i]);
    end
  endtask

  task automatic clear_stats();
    @(negedge clk);
    clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_b[i] = 0; m_d[i] = 0; m_g[i] = 0;
    end
  endtask

  // One generation; board_in is scrambled after the latch, optionally clr_stats lands on the commit edge.
  task automatic run_gen(input logic [N-1:0] b, input bit clr_c);
    int lat;
    lat = 0;
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    board_in = ~b;
    for (int k = 1; k <= 40; k++) begin
      if (clr_c && k == R + 1) clr_stats = 1'b1;
      @(posedge clk);
      #1 clr_stats = 1'b0;
      if (k == 1) chk_i("busy_after_start", longint'(busy_v), 7);
      if (done_v[0]) begin
        lat = k;
        break;
      end
    end
    chk_i("done_latency", longint'(lat), longint'(R + 1));
    chk_i("done_all", longint'(done_v), 7);
    model_gen(b, clr_c);
  endtask

  initial begin
    logic [N-1:0] blink_h, blink_v, blk, corners, corners_w1, b;
    int nd, fe, le;

    cap[0] = 64'hFFFF_FFFF; cap[1] = 64'hFFFF_FFFF; cap[2] = 15;
    mwrap[0] = 1'b1; mwrap[1] = 1'b0; mwrap[2] = 1'b1;
    model_reset();

    blink_h = '0; blink_v = '0; blk = '0; corners = '0;
    for (int k = 6; k <= 8; k++) begin
      blink_h = set_cell(blink_h, 7, k);
      blink_v = set_cell(blink_v, k, 7);
    end
    blk = set_cell(blk, 4, 4); blk = set_cell(blk, 4, 5);
    blk = set_cell(blk, 5, 4); blk = set_cell(blk, 5, 5);
    corners = set_cell(corners, 0, 0); corners = set_cell(corners, 0, 15);
    corners = set_cell(corners, 15, 0);
    corners_w1 = set_cell(corners, 15, 15);

    vecs[0] = '{"blinker_h", blink_h, blink_v, 2, 2, 1'b0, blink_v, 2, 2, 1'b0};
    vecs[1] = '{"blinker_v", blink_v, blink_h, 2, 2, 1'b0, blink_h, 2, 2, 1'b0};
    vecs[2] = '{"block", blk, blk, 0, 0, 1'b1, blk, 0, 0, 1'b1};
    vecs[3] = '{"corners", corners, corners_w1, 1, 0, 1'b0, '0, 0, 3, 1'b0};

    rst_n = 1'b0; start = 1'b0; clr_stats = 1'b0; board_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_i("reset_busy", longint'(busy_v), 0);
    chk_i("reset_done", longint'(done_v), 0);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      clear_stats();
      run_gen(vecs[v].board, 1'b0);
      chk_v({vecs[v].name, "_w1_board"}, bo[0], vecs[v].exp1);
      chk_i({vecs[v].name, "_w1_birth"}, longint'(bc0), longint'(vecs[v].b1));
      chk_i({vecs[v].name, "_w1_death"}, longint'(dc0), longint'(vecs[v].d1));
      chk_i({vecs[v].name, "_w1_still"}, longint'(still_v[0]), longint'(vecs[v].s1));
      chk_i({vecs[v].name, "_w1_gen"}, longint'(gc0), 1);
      chk_v({vecs[v].name, "_w0_board"}, bo[1], vecs[v].exp0);
      chk_i({vecs[v].name, "_w0_birth"}, longint'(bc1), longint'(vecs[v].b0));
      chk_i({vecs[v].name, "_w0_death"}, longint'(dc1), longint'(vecs[v].d0));
      chk_i({vecs[v].name, "_w0_still"}, longint'(still_v[1]), longint'(vecs[v].s0));
      chk_v({vecs[v].name, "_sat_board"}, bo[2], vecs[v].exp1);
      check_all(vecs[v].name);
    end

    // Saturation of the 4-bit counters, then a clear coincident with the commit.
    clear_stats();
    b = blink_h;
    repeat (8) begin
      run_gen(b, 1'b0);
      b = bo[0];
    end
    chk_i("sat_birth", longint'(bc2), 15);
    chk_i("sat_death", longint'(dc2), 15);
    chk_i("sat_gen", longint'(gc2), 8);
    chk_i("wide_birth", longint'(bc0), 16);
    check_all("sat8");
    run_gen(b, 1'b1);
    chk_i("clr_commit_gen", longint'(gc2), 0);
    chk_v("clr_commit_board", bo[2], blink_v);
    check_all("clr_commit");

    // start held high: one generation per R+2 cycles, no queuing.
    clear_stats();
    nd = 0; fe = -1; le = -1;
    @(negedge clk);
    board_in = blink_h;
    start    = 1'b1;
    for (int e = 0; e < 3 * (R + 2); e++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) begin
        nd++;
        if (fe < 0) fe = e;
        le = e;
      end
    end
    start = 1'b0;
    chk_i("held_start_dones", longint'(nd), 3);
    chk_i("held_start_first", longint'(fe), longint'(R + 1));
    chk_i("held_start_last", longint'(le), longint'(3 * (R + 2) - 1));
    repeat (3) model_gen(blink_h, 1'b0);
    check_all("held_start");

    // Reset during a sweep discards the partial generation.
    @(negedge clk);
    board_in = blink_v;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk_i("midreset_busy", longint'(busy_v), 0);
    chk_i("midreset_done", longint'(done_v), 0);
    check_all("midreset");
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done_v != 3'b000) nd++;
    end
    chk_i("midreset_no_done", longint'(nd), 0);
    chk_v("midreset_board_held", bo[0], '0);

    // Random boards against the reference model, with occasional clears at commit.
    for (int t = 0; t < 12; t++) begin
      for (int w = 0; w < N / 32; w++) begin
        b[w*32 +: 32] = (t % 3 == 0) ? ($urandom & $urandom) : $urandom;
      end
      run_gen(b, $urandom_range(0, 3) == 0);
      check_all($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
